// File: rtl/async_fifo_pkg.sv
// Shared types and helpers for the async FIFO pointer logic (read and write sides).
package async_fifo_pkg;

    localparam int c_default_addr_width = 3;
    localparam int c_default_sync_stages = 2;
    localparam int c_ptr_width = c_default_addr_width + 1;

    typedef logic [c_ptr_width-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/async_fifo_rd_ctrl_gray2bin.sv
// Combinational Gray-to-binary decoder; each binary bit is the XOR of all Gray bits at or above it.
module GrayToBin #(
    parameter int p_bit_width = 4
) (
    input  logic [p_bit_width-1:0] gray,
    output logic [p_bit_width-1:0] bin
);

    for (genvar g = 0; g < p_bit_width; g++) begin : g_bit
        assign bin[g] = ^gray[p_bit_width-1:g];
    end

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side pointer controller: synchronizes the writer's Gray pointer, tracks the read pointer,
// and derives empty, occupancy and the dequeue handshake.
module async_fifo_rd_ctrl
    import async_fifo_pkg::*;
#(
    parameter int p_addr_width  = c_default_addr_width,
    parameter int p_sync_stages = c_default_sync_stages
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [p_addr_width:0] wptr_gray_async,
    output logic                  deq_val,
    input  logic                  deq_rdy,
    output logic [p_addr_width-1:0] raddr,
    output logic [p_addr_width:0] rptr_gray,
    output logic                  empty,
    output logic [p_addr_width:0] count
);

    localparam int c_pw = p_addr_width + 1;

    // Handshake: an entry is dequeued on a rising edge where deq_val and deq_rdy are both high.
    logic [p_sync_stages-1:0][c_pw-1:0] r_sync;
    logic [c_pw-1:0] r_rptr_bin;
    logic [c_pw-1:0] r_rptr_gray;
    logic [c_pw-1:0] w_wptr_gray_sync;
    logic [c_pw-1:0] w_wptr_bin;
    logic [c_pw-1:0] w_rptr_next;
    logic [c_pw-1:0] w_rptr_next_gray;
    logic            w_empty;
    logic            w_fire;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= wptr_gray_async;
            for (int i = 1; i < p_sync_stages; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_wptr_gray_sync = r_sync[p_sync_stages-1];

    GrayToBin #(
        .p_bit_width(c_pw)
    ) u_gray2bin (
        .gray(w_wptr_gray_sync),
        .bin (w_wptr_bin)
    );

    // Empty is judged in Gray so it depends only on registered, one-bit-per-step values.
    assign w_empty          = (r_rptr_gray == w_wptr_gray_sync);
    assign w_fire           = !w_empty && deq_rdy;
    assign w_rptr_next      = r_rptr_bin + 1'b1;
    assign w_rptr_next_gray = w_rptr_next ^ (w_rptr_next >> 1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rptr_bin  <= '0;
            r_rptr_gray <= '0;
        end else if (w_fire) begin
            r_rptr_bin  <= w_rptr_next;
            r_rptr_gray <= w_rptr_next_gray;
        end
    end

    assign empty     = w_empty;
    assign deq_val   = !w_empty;
    assign raddr     = r_rptr_bin[p_addr_width-1:0];
    assign rptr_gray = r_rptr_gray;
    assign count     = w_wptr_bin - r_rptr_bin;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Randomized scoreboard bench for async_fifo_rd_ctrl against an integer-pointer FIFO model.
module tb_async_fifo_rd_ctrl;

    localparam int AW = 3;
    localparam int SS = 2;
    localparam int PW = AW + 1;
    localparam int PMOD = 1 << PW;
    localparam int EW = 1 + AW + PW + 1 + 1 + PW;

    logic          clk;
    logic          reset_n;
    logic [PW-1:0] wptr_gray_async;
    logic          deq_val;
    logic          deq_rdy;
    logic [AW-1:0] raddr;
    logic [PW-1:0] rptr_gray;
    logic          empty;
    logic [PW-1:0] count;

    async_fifo_rd_ctrl #(
        .p_addr_width (AW),
        .p_sync_stages(SS)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wptr_gray_async(wptr_gray_async),
        .deq_val        (deq_val),
        .deq_rdy        (deq_rdy),
        .raddr          (raddr),
        .rptr_gray      (rptr_gray),
        .empty          (empty),
        .count          (count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model state: integer pointers, and the write pointer as seen through the sync delay
    int rp;
    int wb;
    int seen [SS];
    int n_checks;
    int n_errors;
    logic [EW-1:0] exp_q[$];

    function automatic logic [PW-1:0] to_gray(input int v);
        logic [PW-1:0] b;
        b = PW'(v);
        return b ^ (b >> 1);
    endfunction

    // one clock cycle of stimulus; prediction of the post-edge outputs goes into exp_q
    task automatic step(input logic rst_n, input int wbin, input logic rdy);
        int vis;
        int cnt;
        logic [EW-1:0] e;
        @(negedge clk);
        reset_n         = rst_n;
        wptr_gray_async = to_gray(wbin % PMOD);
        deq_rdy         = rdy;
        if (!rst_n) begin
            rp = 0;
            for (int i = 0; i < SS; i++) seen[i] = 0;
        end else begin
            vis = seen[SS-1];
            if (rdy && vis != rp) rp = (rp + 1) % PMOD;
            for (int i = SS - 1; i > 0; i--) seen[i] = seen[i-1];
            seen[0] = wbin % PMOD;
        end
        vis = seen[SS-1];
        cnt = (vis - rp + PMOD) % PMOD;
        e = {~rst_n, AW'(rp % (1 << AW)), to_gray(rp), (vis == rp), (vis != rp), PW'(cnt)};
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b1, wb, rdy);
    endtask

    task automatic do_reset(input int wbin);
        step(1'b0, wbin, 1'b0);
    endtask

    // monitor: compares every predicted cycle just after the edge
    logic [PW-1:0] prev_gray;
    logic          prev_ok;
    initial begin
        prev_ok = 1'b0;
        prev_gray = '0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [EW-1:0] e;
                logic          e_rst;
                logic [AW-1:0] e_raddr;
                logic [PW-1:0] e_gray;
                logic          e_empty;
                logic          e_val;
                logic [PW-1:0] e_cnt;
                e = exp_q.pop_front();
                {e_rst, e_raddr, e_gray, e_empty, e_val, e_cnt} = e;
                n_checks++;
                if (raddr !== e_raddr) begin
                    n_errors++;
                    $display("FAIL raddr t=%0t got %0d want %0d", $time, raddr, e_raddr);
                end
                n_checks++;
                if (rptr_gray !== e_gray) begin
                    n_errors++;
                    $display("FAIL rptr_gray t=%0t got %b want %b", $time, rptr_gray, e_gray);
                end
                n_checks++;
                if (empty !== e_empty) begin
                    n_errors++;
                    $display("FAIL empty t=%0t got %b want %b", $time, empty, e_empty);
                end
                n_checks++;
                if (deq_val !== e_val) begin
                    n_errors++;
                    $display("FAIL deq_val t=%0t got %b want %b", $time, deq_val, e_val);
                end
                n_checks++;
                if (count !== e_cnt) begin
                    n_errors++;
                    $display("FAIL count t=%0t got %0d want %0d", $time, count, e_cnt);
                end
                if (prev_ok && !e_rst) begin
                    n_checks++;
                    if ($countones(prev_gray ^ rptr_gray) > 1) begin
                        n_errors++;
                        $display("FAIL gray_onebit t=%0t got %b after %b want at most one bit change",
                                 $time, rptr_gray, prev_gray);
                    end
                end
                prev_gray = rptr_gray;
                prev_ok   = 1'b1;
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rp = 0;
        wb = 0;
        for (int i = 0; i < SS; i++) seen[i] = 0;
        reset_n = 1'b0;
        deq_rdy = 1'b0;
        wptr_gray_async = '0;

        // reset with a nonzero write pointer on the input (gray 0110 = bin 4)
        do_reset(4);
        wb = 0;
        do_reset(0);

        // single entry: visible after two edges, then one dequeue
        wb = 1;
        idle(3, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // fill to depth, drain, extra ready is ignored
        for (int i = 2; i <= 8; i++) begin
            wb = i;
            idle(1, 1'b0);
        end
        idle(3, 1'b0);
        idle(9, 1'b1);

        // walk pointers up to 15 then wrap through zero
        wb = 15;
        idle(3, 1'b0);
        idle(7, 1'b1);
        wb = 16;
        idle(3, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // write advance on the same cycle as a fire with one entry
        wb = wb + 1;
        idle(3, 1'b0);
        wb = wb + 1;
        idle(1, 1'b1);
        idle(3, 1'b0);
        idle(2, 1'b1);

        // reset mid-operation with five entries, write pointer left at 5
        do_reset(0);
        wb = 5;
        idle(3, 1'b0);
        step(1'b0, wb, 1'b1);
        idle(3, 1'b0);

        // randomized traffic with occasional reset of both sides
        do_reset(0);
        wb = 0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                wb = 0;
                do_reset(0);
            end else begin
                if (((wb - rp + PMOD) % PMOD) < (1 << AW) && $urandom_range(0, 2) != 0)
                    wb = (wb + 1) % PMOD;
                step(1'b1, wb, 1'($urandom_range(0, 1)));
            end
        end
        idle(4, 1'b1);

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/async_fifo_rd_ctrl.md
Name: async_fifo_rd_ctrl

Overview:
Read-side (consumer-end) pointer controller for the team's async FIFO. It synchronizes the Gray-coded write pointer from the writer's domain and decodes it back to binary. It maintains the read pointer in binary and Gray form, and derives empty, occupancy and a val/rdy dequeue handshake. It is the counterpart of the write-side Gray encoding: the writer publishes Gray, this block consumes and decodes it.

Parameters:
p_addr_width, 3, FIFO address width; depth = 2**p_addr_width; pointers are p_addr_width+1 bits (extra wrap bit)
p_sync_stages, 2, flop stages in the write-pointer synchronizer; legal range 2..4

Ports:
clk  in  1  read-domain clock
reset_n  in  1  synchronous active-low reset, sampled on rising edge of clk
wptr_gray_async  in  p_addr_width+1  Gray write pointer from write domain (asynchronous to clk)
deq_val  out  1  entry available at raddr
deq_rdy  in  1  consumer accepts entry this cycle
raddr  out  p_addr_width  memory read address = rptr_bin[p_addr_width-1:0]
rptr_gray  out  p_addr_width+1  registered Gray read pointer, sent to write domain
empty  out  1  FIFO empty as seen by read domain
count  out  p_addr_width+1  occupancy = (wptr_bin - rptr_bin) mod 2**(p_addr_width+1)

Behaviour:
- Reset (reset_n=0 at a rising edge): all sync stages, rptr_bin and rptr_gray go to 0. Next cycle: raddr=0, rptr_gray=0, empty=1, deq_val=0, count=0. Reset overrides a simultaneous fire.
- Synchronizer: wptr_gray_async passes through p_sync_stages flops, and only the last stage (wptr_gray_sync) is used. No combinational logic before the first stage.
- Decode: wptr_bin = Gray-to-binary of wptr_gray_sync, with bin[MSB]=gray[MSB] and bin[i]=bin[i+1]^gray[i]. This is purely combinational from a registered value.
- Latency: a stable change on wptr_gray_async sampled at edge k is reflected in empty/count/deq_val after edge k+p_sync_stages-1 (p_sync_stages edges inclusive).
- empty = (rptr_gray == wptr_gray_sync). The comparison is done in Gray, not binary.
- deq_val = !empty. fire = deq_val & deq_rdy.
- On fire: rptr_bin <= rptr_bin+1, which wraps mod 2**(p_addr_width+1). On the same edge rptr_gray <= next_bin ^ (next_bin>>1). rptr_gray is always a direct flop output, so exactly one bit changes per increment.
- deq_rdy while empty: ignored, no pointer change.
- Wrap-around: rptr_bin all-ones → 0 on fire, and the wrap bit toggles. raddr wraps from depth-1 to 0.
- count is combinational from registered values. Legal range is 0..depth. A value > depth indicates a writer protocol violation; the block does not correct it.
- Reset mid-operation: state clears regardless of count. After reset_n rises, a still-nonzero wptr_gray_async reappears after p_sync_stages edges. The FIFO must be reset in both domains together; this block does not enforce that.
- No state machine beyond the pointer and sync registers. There is no output data path; the memory is external.

Decomposition:
- Shared package async_fifo_pkg:
  - localparam helper for pointer width (p_addr_width+1)
  - typedef for the pointer vector
  - function bin2gray
- One combinational sub-module, GrayToBin (parameter p_bit_width, ports gray→bin). It mirrors the existing encoder and is reused by the future write-side full logic.
- The synchronizer is inline: a generate loop of flops.

Test Plan:
(All with p_addr_width=3, p_sync_stages=2.)
1. Reset: hold reset_n=0 one edge with wptr_gray_async=4'b0110 → next cycle rptr_gray=0, raddr=0, empty=1, deq_val=0, count=0.
2. Single entry: set wptr_gray_async=4'b0001 after reset, deq_rdy=0 → deq_val=0 for 1 cycle, then deq_val=1, count=1. Pulse deq_rdy=1 one cycle → raddr 0→1, rptr_gray=4'b0001, empty=1, count=0.
3. Full then drain: step wptr_gray_async through the Gray codes for 1..8, ending at 4'b1100 → count=8. Then deq_rdy=1 for 8 cycles → raddr 0,1,…,7,0; final rptr_gray=4'b1100, empty=1; deq_rdy held a 9th cycle changes nothing.
4. Pointer wrap: preload via writes/reads to rptr_bin=15 (rptr_gray=4'b1000), write pointer at 0 (gray 0000) → count=1. Fire → rptr_bin=0, rptr_gray=4'b0000, empty=1; check only one bit of rptr_gray toggled.
5. Simultaneous events: write pointer advances on the same cycle as a fire with count=1 → count stays 1 two cycles later, deq_val remains 1, no glitch in empty.
6. Reset mid-operation: count=5, deq_rdy=1, assert reset_n=0 one edge → all outputs zero/empty. After release with wptr_gray_async unchanged (bin 5), count=5 returns after 2 edges and raddr=0.
